shift_sequencer: RTL

//   Sequences a WIDTH-bit parallel-load / shift-left register as a full-duplex serial engine.

---
 rtl/shift_sequencer_pkg.sv | 16 +
 rtl/shift_sequencer_core.sv | 30 +++
 rtl/shift_sequencer.sv | 104 ++++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer family: state encodings and
// the bit-counter width helper.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width of a counter that must hold values 0..width-1 (at least one bit).
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_sequencer_core.sv
// Parallel-load / shift-left register. Load has priority over shift; the
// register holds when neither is asserted.
module shift_reg_core #(
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  // Register update: reset, then parallel load, then shift-left with sin into the LSB.
  always_ff @(posedge C) begin
    if (R) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= d;
    end else if (shift) begin
      q_q <= {q_q[WIDTH-2:0], sin};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_sequencer.sv
// Full-duplex serial engine: accepts a parallel word, shifts it out MSB-first
// one bit per serial handshake while shifting ser_in into the LSB, then
// pulses done with the received word in Q.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  input  logic             ser_in,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] bit_cnt_d;
  logic             load;
  logic             shift;
  logic [WIDTH-1:0] q_w;

  // Handshake decode: outputs depend only on registered state and reset, so
  // there is no combinational path from any other input to an output.
  assign in_ready  = (state_q == IDLE)  && !R;
  assign ser_valid = (state_q == SHIFT) && !R;
  assign done      = (state_q == DONE)  && !R;
  assign busy      = (state_q != IDLE)  && !R;

  // Abort suppresses the shift, so an aborted final bit leaves Q untouched.
  assign load  = in_valid && in_ready;
  assign shift = ser_valid && ser_ready && !abort;

  // State and bit-counter registers.
  always_ff @(posedge C) begin
    if (R) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Next-state and bit-counter logic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          bit_cnt_d = CNT_W'(WIDTH - 1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (shift) begin
          if (bit_cnt_q == '0) begin
            state_d = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  shift_reg_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .C    (C),
    .R    (R),
    .load (load),
    .shift(shift),
    .d    (in_data),
    .sin  (ser_in),
    .q    (q_w)
  );

  assign Q       = q_w;
  assign nQ      = ~q_w;
  assign ser_out = q_w[WIDTH-1];

endmodule
